// File: rtl/cpa_share_pkg.sv
// cpa_share_pkg: shared defaults, id width helper and response record for cpa_share_arb
package cpa_share_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 14;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0]        sum;
        logic                        cout;
        logic [id_w(DEF_NUM_REQ)-1:0] id;
    } rsp_t;
endpackage

// File: rtl/MG_CPA.sv
// MG_CPA: 14-bit carry-propagate adder macro (behavioural view of the library cell)
module MG_CPA (
    input  logic [13:0] a,
    input  logic [13:0] b,
    output logic [13:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search from ptr upward with wrap; pointer register lives in the parent
module rr_arbiter import cpa_share_pkg::*; #(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic [ID_W-1:0]    next_ptr
);
    logic            found;
    logic [ID_W-1:0] idx;

    // scan farthest-first so the candidate closest to ptr is the last to overwrite
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
        gnt      = (en && found) ? NUM_REQ'(1) << gnt_idx : '0;
        next_ptr = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/cpa_share_arb.sv
// cpa_share_arb: round-robin sharing of one carry-propagate adder across NUM_REQ requesters.
// CPA_SHARE_IN_REG_EN adds an operand register stage ahead of the adder (latency 2).
module cpa_share_arb import cpa_share_pkg::*; #(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = DEF_WIDTH,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);
    logic               slot_free, feed_en, xfer, load_rsp, cpa_cout;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx, next_ptr, rr_ptr, cpa_id;
    logic [WIDTH-1:0]   win_a, win_b, cpa_a, cpa_b, cpa_sum;

    assign slot_free = !rsp_valid || rsp_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .en       (feed_en && rst_n),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .next_ptr (next_ptr)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign win_a     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign win_b     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= next_ptr;
    end

`ifdef CPA_SHARE_IN_REG_EN
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [ID_W-1:0]  s1_id;

    assign feed_en  = !s1_valid || slot_free;
    assign load_rsp = s1_valid && slot_free;
    assign cpa_a    = s1_a;
    assign cpa_b    = s1_b;
    assign cpa_id   = s1_id;

    // s1 either hands its operands to the slot or refills from the grant in the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (feed_en) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_a  <= win_a;
                s1_b  <= win_b;
                s1_id <= gnt_idx;
            end
        end
    end
`else
    assign feed_en  = slot_free;
    assign load_rsp = xfer;
    assign cpa_a    = win_a;
    assign cpa_b    = win_b;
    assign cpa_id   = gnt_idx;
`endif

    generate
        if (WIDTH == 14) begin : g_mg
            MG_CPA u_cpa (
                .a    (cpa_a),
                .b    (cpa_b),
                .sum  (cpa_sum),
                .cout (cpa_cout)
            );
        end else begin : g_beh
            assign {cpa_cout, cpa_sum} = {1'b0, cpa_a} + {1'b0, cpa_b};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else if (load_rsp) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= cpa_sum;
            rsp_cout  <= cpa_cout;
            rsp_id    <= cpa_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule
